// File: rtl/keyed_lock_pkg.sv
// Shared types and register-map constants for the keyed lock register block.
package keyed_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY_WAIT = 2'd1,
    UNLOCKED = 2'd2
  } lock_state_e;

  // Byte offsets from BASE_ADDR
  localparam int OFS_LOCK   = 0;
  localparam int OFS_KEY    = 4;
  localparam int OFS_STATUS = 8;
  localparam int OFS_DATA0  = 12;

  // STATUS register fields
  localparam int STAT_UNLOCKED = 0;
  localparam int STAT_WR_ERR   = 1;
  localparam int STAT_KEY_ERR  = 2;
  localparam int STAT_CNT_CLR  = 3;
  localparam int STAT_CNT_LSB  = 8;

endpackage

// File: rtl/keyed_lock_fsm.sv
// Two-key unlock sequence with a timed window and a one-shot relock after a LOCK_CTRL write.
module keyed_lock_fsm
  import keyed_lock_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] KEY0           = DATA_WIDTH'(32'h0000_C0DE),
  parameter logic [DATA_WIDTH-1:0] KEY1           = DATA_WIDTH'(32'h0000_D00D),
  parameter int                    UNLOCK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_any_i,
  input  logic                  key_wr_i,
  input  logic                  lock_wr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output lock_state_e           state_o,
  output logic                  key_err_o
);

  localparam int TW = $clog2(UNLOCK_TIMEOUT + 1);

  lock_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          relock_q, relock_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOCKED;
      timer_q  <= '0;
      relock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      relock_q <= relock_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    relock_d  = 1'b0;
    key_err_o = 1'b0;
    unique case (state_q)
      LOCKED: begin
        if (key_wr_i) begin
          if (wdata_i == KEY0) state_d = KEY_WAIT;
          else                 key_err_o = 1'b1;
        end
      end
      KEY_WAIT: begin
        if (wr_any_i) begin
          if (key_wr_i && (wdata_i == KEY1)) begin
            state_d = UNLOCKED;
            timer_d = TW'(UNLOCK_TIMEOUT);
          end else begin
            state_d   = LOCKED;
            key_err_o = 1'b1;
          end
        end
      end
      UNLOCKED: begin
        timer_d  = timer_q - 1'b1;
        relock_d = relock_q | lock_wr_i;
        // Window closes when the timer would reach zero, or one cycle after a mask update.
        if (relock_q || (timer_q == TW'(1))) begin
          state_d  = LOCKED;
          timer_d  = '0;
          relock_d = 1'b0;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/keyed_lock_regfile.sv
// Lockable register file: per-register lock mask guarded by a key sequence, blocked-write status.
module keyed_lock_regfile
  import keyed_lock_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_REGS       = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(8'h10),
  parameter logic [DATA_WIDTH-1:0] KEY0           = DATA_WIDTH'(32'h0000_C0DE),
  parameter logic [DATA_WIDTH-1:0] KEY1           = DATA_WIDTH'(32'h0000_D00D),
  parameter int                    UNLOCK_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           chip_select,
  input  logic                           write_en,
  input  logic                           read_en,
  input  logic [DATA_WIDTH-1:0]          write_data,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           data_valid,
  output logic [NUM_REGS-1:0]            lock_mask_o,
  output logic                           unlocked_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int WW    = ADDR_WIDTH - 2;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [WW-1:0]    W_LOCK   = WW'(OFS_LOCK / 4);
  localparam logic [WW-1:0]    W_KEY    = WW'(OFS_KEY / 4);
  localparam logic [WW-1:0]    W_STATUS = WW'(OFS_STATUS / 4);
  localparam logic [WW-1:0]    W_DATA0  = WW'(OFS_DATA0 / 4);
  localparam logic [WW-1:0]    W_END    = WW'(OFS_DATA0 / 4 + NUM_REGS);
  localparam logic [IDX_W-1:0] I_DATA0  = IDX_W'(OFS_DATA0 / 4);

  logic                  wr_act, rd_act;
  logic [AW1-1:0]        rel;
  logic [WW-1:0]         word;
  logic                  in_map, hit_lock, hit_key, hit_status, hit_data;
  logic [IDX_W-1:0]      data_idx;
  lock_state_e           state;
  logic                  unlocked, key_err_evt;
  logic                  lock_wr_ok, data_wr_ok, blocked, status_wr;
  logic [NUM_REGS-1:0]   mask_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_err_q, wr_err_d, key_err_q, key_err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  dvalid_q;

  assign wr_act = chip_select & write_en;
  assign rd_act = chip_select & read_en;

  // Borrow out of the subtraction marks addresses below the block; BASE_ADDR is word aligned.
  assign rel        = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign word       = rel[ADDR_WIDTH-1:2];
  assign in_map     = ~rel[ADDR_WIDTH] & (rel[1:0] == 2'b00) & (word < W_END);
  assign hit_lock   = in_map & (word == W_LOCK);
  assign hit_key    = in_map & (word == W_KEY);
  assign hit_status = in_map & (word == W_STATUS);
  assign hit_data   = in_map & (word >= W_DATA0);
  assign data_idx   = word[IDX_W-1:0] - I_DATA0;

  assign unlocked   = (state == UNLOCKED);
  assign lock_wr_ok = wr_act & hit_lock & unlocked;
  assign data_wr_ok = wr_act & hit_data & ~mask_q[data_idx];
  assign blocked    = wr_act & ((hit_lock & ~unlocked) | (hit_data & mask_q[data_idx]));
  assign status_wr  = wr_act & hit_status;

  keyed_lock_fsm #(
    .DATA_WIDTH    (DATA_WIDTH),
    .KEY0          (KEY0),
    .KEY1          (KEY1),
    .UNLOCK_TIMEOUT(UNLOCK_TIMEOUT)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .wr_any_i (wr_act),
    .key_wr_i (wr_act & hit_key),
    .lock_wr_i(lock_wr_ok),
    .wdata_i  (write_data),
    .state_o  (state),
    .key_err_o(key_err_evt)
  );

  // W1C clears lose to a same-cycle error event.
  always_comb begin
    wr_err_d  = (wr_err_q & ~(status_wr & write_data[STAT_WR_ERR])) | blocked;
    key_err_d = (key_err_q & ~(status_wr & write_data[STAT_KEY_ERR])) | key_err_evt;
    cnt_d     = cnt_q;
    if (status_wr && write_data[STAT_CNT_CLR]) cnt_d = '0;
    if (blocked && (cnt_q != 8'hFF))           cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    rdata_d = '0;
    if (hit_lock && unlocked) begin
      rdata_d[NUM_REGS-1:0] = mask_q;
    end else if (hit_status) begin
      rdata_d[STAT_UNLOCKED]        = unlocked;
      rdata_d[STAT_WR_ERR]          = wr_err_q;
      rdata_d[STAT_KEY_ERR]         = key_err_q;
      rdata_d[STAT_CNT_LSB +: 8]    = cnt_q;
    end else if (hit_data) begin
      rdata_d = regs_q[data_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= '1;
      wr_err_q  <= 1'b0;
      key_err_q <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      dvalid_q  <= 1'b0;
      // NOTE: these are discrete flops with a defined reset value, so resetting the array is intended.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (lock_wr_ok) mask_q <= write_data[NUM_REGS-1:0];
      if (data_wr_ok) regs_q[data_idx] <= write_data;
      wr_err_q  <= wr_err_d;
      key_err_q <= key_err_d;
      cnt_q     <= cnt_d;
      dvalid_q  <= rd_act;
      if (rd_act) rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign read_data   = rdata_q;
  assign data_valid  = dvalid_q;
  assign lock_mask_o = mask_q;
  assign unlocked_o  = unlocked;

endmodule
